mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller for a classic 5-stage MIPS core.
//
// The arithmetic result is computed combinationally when a mult/multu/div/divu
// is accepted in E and parked in tmp_hi/tmp_lo. A down-counter then models the
// multi-cycle latency: HI/LO are only updated on the last busy edge, so the
// architectural registers change exactly when busy falls. While an operation
// is in flight, any MDU instruction sitting in D is held back by stall.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdout
);

    // -------------------------------------------------------------------------
    // Operation codes as seen on mdop; 9-15 decode to nothing.
    // -------------------------------------------------------------------------
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;

    // Counter must hold the longer of the two latencies.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State registers and their next-state values
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_hi;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        r_lo;
    logic [31:0]        w_lo_nxt;
    logic [31:0]        r_tmp_hi;
    logic [31:0]        w_tmp_hi_nxt;
    logic [31:0]        r_tmp_lo;
    logic [31:0]        w_tmp_lo_nxt;
    // Set when the pending operation is a divide by zero: completion then
    // leaves HI/LO untouched instead of committing tmp_hi/tmp_lo.
    logic               r_tmp_keep;
    logic               w_tmp_keep_nxt;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic w_is_mul;
    logic w_is_div;
    logic w_start_op;
    logic w_idle;

    assign w_is_mul   = (mdop == OP_MULT) || (mdop == OP_MULTU);
    assign w_is_div   = (mdop == OP_DIV)  || (mdop == OP_DIVU);
    assign w_start_op = w_is_mul || w_is_div;
    assign w_idle     = (r_state == S_IDLE);

    // -------------------------------------------------------------------------
    // Datapath: 64-bit products and 32-bit quotient/remainder.
    // The divisor is forced to 1 when B is zero so the divider never sees a
    // zero operand; that result is discarded through r_tmp_keep anyway.
    // -------------------------------------------------------------------------
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_div_b;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};
    assign w_div_b  = (B == 32'd0) ? 32'd1 : B;
    // Signed / and % truncate toward zero; the remainder follows the dividend.
    assign w_quo_s  = $signed(A) / $signed(w_div_b);
    assign w_rem_s  = $signed(A) % $signed(w_div_b);
    assign w_quo_u  = A / w_div_b;
    assign w_rem_u  = A % w_div_b;

    // Select the 64-bit result of the operation being started.
    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branching, so no path leaves it unassigned and no latch is inferred.
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (mdop)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV: begin
                w_res_hi = w_rem_s;
                w_res_lo = w_quo_s;
            end
            OP_DIVU: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // Next-state logic: accept starts and moves in IDLE, count down in RUN.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_tmp_hi_nxt   = r_tmp_hi;
        w_tmp_lo_nxt   = r_tmp_lo;
        w_tmp_keep_nxt = r_tmp_keep;

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    if (w_start_op) begin
                        w_tmp_hi_nxt   = w_res_hi;
                        w_tmp_lo_nxt   = w_res_lo;
                        w_tmp_keep_nxt = w_is_div && (B == 32'd0);
                        w_cnt_nxt      = w_is_mul ? CNT_MULT : CNT_DIV;
                        w_state_nxt    = S_RUN;
                    end else if (mdop == OP_MTHI) begin
                        w_hi_nxt = A;
                    end else if (mdop == OP_MTLO) begin
                        w_lo_nxt = A;
                    end
                end
            end
            S_RUN: begin
                // Anything presented on en/mdop here is ignored: the stall
                // keeps legal code from issuing MDU work during a run.
                if (r_cnt <= CNT_ONE) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (!r_tmp_keep) begin
                        w_hi_nxt = r_tmp_hi;
                        w_lo_nxt = r_tmp_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
        endcase
    end

    // State register with synchronous, active-high reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_tmp_hi   <= 32'd0;
            r_tmp_lo   <= 32'd0;
            r_tmp_keep <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_tmp_hi   <= w_tmp_hi_nxt;
            r_tmp_lo   <= w_tmp_lo_nxt;
            r_tmp_keep <= w_tmp_keep_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy  = !w_idle;
    assign HI    = r_hi;
    assign LO    = r_lo;
    // Reads see the registers directly, so a read in the cycle busy falls
    // already returns the freshly committed value.
    assign mdout = (mdop == OP_MFHI) ? r_hi : r_lo;
    // A start in E or any in-flight op (including its last cycle) holds back
    // an MDU instruction in D; non-MDU instructions are never stalled.
    assign stall = D_md && (busy || (en && w_start_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- scoreboard bench for mdu_ctrl.
// The stimulus process keeps an architectural HI/LO model, computes each
// operation's result with plain integer arithmetic and queues the expectation.
// A monitor process pops and compares whenever busy falls (HI, LO, busy
// length) and whenever an mfhi/mflo is presented (mdout).
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_md;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdout;

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .D_md  (D_md),
        .busy  (busy),
        .stall (stall),
        .HI    (HI),
        .LO    (LO),
        .mdout (mdout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] rd_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          abort_flag = 1'b0;

    // Architectural model of HI/LO after all issued operations complete.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from the instruction set definition.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        int              sa;
        int              sb;
        longint          ps;
        longint unsigned pu;
        longint unsigned ua;
        longint unsigned ub;
        e.hi = m_hi;
        e.lo = m_lo;
        e.cyc = (op <= 4'd2) ? MULT_N : DIV_N;
        sa = a;
        sb = b;
        case (op)
            4'd1: begin
                ps   = longint'(sa) * longint'(sb);
                e.hi = ps[63:32];
                e.lo = ps[31:0];
            end
            4'd2: begin
                ua   = a;
                ub   = b;
                pu   = ua * ub;
                e.hi = pu[63:32];
                e.lo = pu[31:0];
            end
            4'd3: begin
                if (b != 32'd0) begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            default: begin
                if (b != 32'd0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Issue a mult/multu/div/divu; returns in the first busy cycle.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        sb_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        en = 1'b1; mdop = op; A = a; B = b;
        tick();
        en = 1'b0; mdop = 4'd0;
    endtask

    task automatic move_op(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd5) m_hi = a;
        else            m_lo = a;
        en = 1'b1; mdop = op; A = a;
        tick();
        en = 1'b0; mdop = 4'd0;
    endtask

    task automatic read_op(input logic [3:0] op);
        rd_q.push_back((op == 4'd7) ? m_hi : m_lo);
        en = 1'b1; mdop = op;
        tick();
        en = 1'b0; mdop = 4'd0;
    endtask

    // Returns in the cycle busy has fallen, bounded by a cycle budget.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", busy, 1'b0);
    endtask

    // Monitor: compare completions and reads against queued expectations.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                if (abort_flag) begin
                    abort_flag = 1'b0;
                end else if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_completion: busy fell after %0d cycles, none pending", busy_run);
                end else begin
                    e = sb_q.pop_front();
                    check("HI_done", HI, e.hi);
                    check("LO_done", LO, e.lo);
                    check("busy_len", busy_run, e.cyc);
                end
                busy_run = 0;
            end
            if (en && (mdop == 4'd7 || mdop == 4'd8)) begin
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_read: mdout %h with no expectation", mdout);
                end else begin
                    check("mdout", mdout, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int          cnt;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;

        reset = 1'b1; en = 1'b0; mdop = 4'd0; A = 32'd0; B = 32'd0; D_md = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy",  busy,  1'b0);
        check("rst_HI",    HI,    32'd0);
        check("rst_LO",    LO,    32'd0);
        check("rst_mdout", mdout, 32'd0);
        check("rst_stall", stall, 1'b0);
        D_md = 1'b1;
        #1;
        check("idle_stall_no_start", stall, 1'b0);
        D_md = 1'b0;

        // Signed and unsigned multiply with a negative operand
        start_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle();
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFFE);
        start_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle();
        check("multu_HI", HI, 32'h0000_0001);
        check("multu_LO", LO, 32'hFFFF_FFFE);

        // Signed divide with an MDU instruction waiting in D throughout
        D_md = 1'b1;
        e = model(4'd3, 32'hFFFF_FFF9, 32'd2);
        sb_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        en = 1'b1; mdop = 4'd3; A = 32'hFFFF_FFF9; B = 32'd2;
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (stall) cnt++;
            tick();
            en = 1'b0; mdop = 4'd0;
        end
        check("div_stall_len", cnt, 11);
        check("div_LO", LO, 32'hFFFF_FFFD);
        check("div_HI", HI, 32'hFFFF_FFFF);
        D_md = 1'b0;

        // Divide by zero leaves LO as written by mtlo
        move_op(4'd6, 32'h1234_5678);
        start_op(4'd4, 32'd7, 32'd0);
        check("stall_non_md_in_run", stall, 1'b0);
        wait_idle();
        check("div0_LO", LO, 32'h1234_5678);

        // Reset three cycles into a mult of 3x4
        start_op(4'd1, 32'd3, 32'd4);
        tick();
        tick();
        void'(sb_q.pop_back());
        abort_flag = 1'b1;
        reset = 1'b1;
        tick();
        check("abort_busy", busy, 1'b0);
        check("abort_HI",   HI,   32'd0);
        check("abort_LO",   LO,   32'd0);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 8; i++) begin
            check("abort_LO_stays", LO, 32'd0);
            tick();
        end

        // mflo in the cycle busy falls, then a second mult right after
        start_op(4'd1, 32'd3, 32'd4);
        wait_idle();
        read_op(4'd8);
        start_op(4'd1, 32'd5, 32'd6);
        wait_idle();
        // Start in the very cycle busy falls
        start_op(4'd3, 32'd100, 32'd7);
        wait_idle();
        read_op(4'd7);

        // Randomized mix, including ignored MDU ops presented during a run
        for (int k = 0; k < 60; k++) begin
            op   = 4'($urandom_range(1, 8));
            D_md = 1'($urandom_range(0, 1));
            a    = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            if (op <= 4'd4) begin
                start_op(op, a, b);
                check("stall_in_run", stall, D_md);
                if ($urandom_range(0, 2) == 0) begin
                    en = 1'b1; mdop = 4'($urandom_range(1, 6));
                    A = $urandom; B = $urandom;
                    tick();
                    en = 1'b0; mdop = 4'd0;
                end
                wait_idle();
            end else if (op <= 4'd6) begin
                move_op(op, a);
            end else begin
                read_op(op);
            end
        end
        D_md = 1'b0;

        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);
        check("rd_drained", rd_q.size(), 0);
        check("final_HI", HI, m_hi);
        check("final_LO", LO, m_lo);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
